stream_narrow_in_arb: RTL
=========================

Name: stream_narrow_in_arb

Overview:
Round-robin arbiter that shares one 256-bit input port of the stream narrowing buffer between NUM_SRC 256-bit producers.
Each grant is held for exactly BURST_BEATS accepted beats. The default of 3 beats is 768 bits, one full narrowing buffer. This keeps every source's data aligned to buffer boundaries, so one source's data never mixes with another's inside a buffer.
Sits directly upstream of the narrower; its master side connects straight to the narrower's stream_in, stream_in_valid and stream_in_ready.

Parameters:
NUM_SRC, 4, number of requesting 256-bit sources (2..8)
SRC_WIDTH, 2, width of a source index; must satisfy 2**SRC_WIDTH >= NUM_SRC
BURST_BEATS, 3, accepted beats per grant (1..15)
CNT_WIDTH, 4, width of the beat counter; must satisfy 2**CNT_WIDTH > BURST_BEATS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
src_data  in  NUM_SRC*256  source data; source i occupies bits [256*i +: 256]
src_valid  in  NUM_SRC  per-source valid
src_ready  out  NUM_SRC  per-source ready
src_enable  in  NUM_SRC  configuration mask; a source with its bit at 0 is never newly granted
m_data  out  256  data to the narrower
m_valid  out  1  valid to the narrower
m_ready  in  1  ready from the narrower
grant_id  out  SRC_WIDTH  index of the source currently or last granted
busy  out  1  high while a burst is in progress (state GRANT)
burst_done  out  1  one-cycle pulse in the cycle the final beat of a burst is accepted

Behaviour:
- Reset (async assert, released synchronously to clk):
  - state=IDLE, beat_cnt=0, rr_ptr=0, grant_id=0.
  - busy=0, burst_done=0, m_valid=0, src_ready=all 0, m_data=0.
- Request vector: req[i] = src_valid[i] & src_enable[i].
- State IDLE:
  - m_valid=0, src_ready=0, m_data=0.
  - If any req is set: pick the first set req[i] scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_SRC.
  - On that clock edge: grant_id<=i, beat_cnt<=0, state<=GRANT.
  - Arbitration latency is 1 cycle from valid to grant. No data is transferred in IDLE.
- State GRANT (data path is combinational pass-through, zero latency):
  - m_data = src_data[grant_id], m_valid = src_valid[grant_id].
  - src_ready[grant_id] = m_ready; all other src_ready = 0.
  - A beat is accepted when m_valid & m_ready; on each accepted beat beat_cnt increments.
  - On the accepted beat where beat_cnt == BURST_BEATS-1:
    - burst_done=1 (combinational pulse).
    - state<=IDLE, rr_ptr<=(grant_id+1) mod NUM_SRC, beat_cnt<=0.
- A burst is never preempted or truncated. Deasserting src_enable[grant_id] or src_valid[grant_id] mid-burst only stalls the burst; the grant is held until BURST_BEATS beats are accepted.
- Inter-burst gap: exactly 1 idle cycle (the IDLE arbitration cycle) between the last beat of one burst and the first beat of the next.
- Fairness: with all sources requesting continuously, grant order is 0,1,...,NUM_SRC-1,0,...
- No-request case: rr_ptr does not change in IDLE.
- Index wrap: rr_ptr and grant_id wrap modulo NUM_SRC, not 2**SRC_WIDTH. Indices >= NUM_SRC never occur.
- Stability: grant_id holds its value in IDLE until the next grant.
- Reset mid-burst: the burst is abandoned immediately. All outputs return to their reset values, and the next grant starts with source 0 having priority.
- Protocol: the block does not require src_valid to stay high, but it never drops m_valid of its own accord in GRANT. Any valid drop comes from the source.

Test Plan:
1. Only source 2 requesting with src_data=beats A,B,C, m_ready=1 -> cycle 1 IDLE; cycles 2-4 m_data=A,B,C; burst_done in cycle 4; grant_id=2; busy high in cycles 2-4; then IDLE with rr_ptr=3.
2. All 4 sources valid continuously, m_ready=1 -> grant_id sequence 0,1,2,3,0. Each burst is exactly 3 beats, with a 1-cycle gap between bursts.
3. Source 0 granted, m_ready toggles 1,0,0,1,0,1 -> exactly 3 beats accepted, only in the cycles where m_ready=1. src_ready[1..3]=0 throughout. burst_done coincides with the 3rd acceptance.
4. src_enable=4'b1010, all sources valid -> grants alternate 1,3,1,3; sources 0 and 2 never see src_ready=1.
5. Source 1 granted; after beat 1, src_enable[1] and src_valid[1] drop for 5 cycles, then return -> busy stays 1 and grant_id stays 1. Two more beats are transferred, then IDLE.
6. rst asserted mid-burst after beat 2 of source 3, with all sources still valid -> m_valid and busy go 0 immediately. After release, the first grant is to source 0 with a fresh 3-beat burst.

Source files
------------

// File: rtl/stream_narrow_in_arb.sv
// Round-robin arbiter feeding the 256-bit input of the stream narrowing buffer.
// A grant is held for exactly BURST_BEATS accepted beats, so each narrowing buffer
// is filled by a single source and data from different sources never shares a buffer.
module stream_narrow_in_arb #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SRC_WIDTH   = 2,
  parameter int unsigned BURST_BEATS = 3,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_SRC*256-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]     i_src_valid,
  output logic [NUM_SRC-1:0]     o_src_ready,
  input  logic [NUM_SRC-1:0]     i_src_enable,
  output logic [255:0]           o_m_data,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [SRC_WIDTH-1:0]   o_grant_id,
  output logic                   o_busy,
  output logic                   o_burst_done
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [SRC_WIDTH-1:0] LastIdx  = SRC_WIDTH'(NUM_SRC - 1);
  localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(BURST_BEATS - 1);

  state_e                 r_state, w_state_d;
  logic [CNT_WIDTH-1:0]   r_beat_cnt, w_beat_cnt_d;
  logic [SRC_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_d;
  logic [SRC_WIDTH-1:0]   r_grant_id, w_grant_id_d;

  logic [NUM_SRC-1:0]     w_req;
  logic                   w_found;
  logic [SRC_WIDTH-1:0]   w_pick;
  logic [SRC_WIDTH-1:0]   w_scan;
  logic [255:0]           w_sel_data;
  logic                   w_sel_valid;
  logic                   w_accept;

  assign w_req      = i_src_valid & i_src_enable;
  assign o_grant_id = r_grant_id;
  assign o_busy     = (r_state == StGrant);

  // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!w_found && w_req[w_scan]) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
      w_scan = (w_scan == LastIdx) ? '0 : w_scan + 1'b1;
    end
  end

  // Select the granted source's data and valid.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_grant_id == SRC_WIDTH'(i)) begin
        w_sel_data  = i_src_data[256*i +: 256];
        w_sel_valid = i_src_valid[i];
      end
    end
  end

  // Next-state logic and the combinational master-side outputs.
  always_comb begin
    w_state_d    = r_state;
    w_beat_cnt_d = r_beat_cnt;
    w_rr_ptr_d   = r_rr_ptr;
    w_grant_id_d = r_grant_id;
    o_m_data     = '0;
    o_m_valid    = 1'b0;
    o_src_ready  = '0;
    o_burst_done = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_id_d = w_pick;
          w_beat_cnt_d = '0;
          w_state_d    = StGrant;
        end
      end
      StGrant: begin
        o_m_data                = w_sel_data;
        o_m_valid               = w_sel_valid;
        o_src_ready[r_grant_id] = i_m_ready;
        w_accept                = w_sel_valid & i_m_ready;
        if (w_accept) begin
          if (r_beat_cnt == LastBeat) begin
            o_burst_done = 1'b1;
            w_state_d    = StIdle;
            w_beat_cnt_d = '0;
            w_rr_ptr_d   = (r_grant_id == LastIdx) ? '0 : r_grant_id + 1'b1;
          end else begin
            w_beat_cnt_d = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_d;
      r_beat_cnt <= w_beat_cnt_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_grant_id <= w_grant_id_d;
    end
  end

endmodule
